// File: rtl/mic1_regfile_if.sv
// mic1_regfile_if: word (MAR/MDR) and byte-fetch (PC/MBR) memory channels
interface mic1_regfile_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_rdata;
  logic        mem_rdy;
  logic [31:0] fetch_addr;
  logic        fetch_req;
  logic [7:0]  fetch_rdata;
  logic        fetch_rdy;
  modport master (
    output mem_addr, mem_wdata, mem_rd_req, mem_wr_req, fetch_addr, fetch_req,
    input  mem_rdata, mem_rdy, fetch_rdata, fetch_rdy
  );
  modport slave (
    input  mem_addr, mem_wdata, mem_rd_req, mem_wr_req, fetch_addr, fetch_req,
    output mem_rdata, mem_rdy, fetch_rdata, fetch_rdy
  );
endinterface

// File: rtl/mic1_regfile.sv
// mic1_regfile: MIC-1 register file, A/B bus drive and word/byte memory channels with stall
module mic1_regfile (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           Shift,
  input  logic [8:0]            C_en,
  input  logic [3:0]            B_sel,
  input  logic                  rd,
  input  logic                  wr,
  input  logic                  fetch,
  output logic [31:0]           A_bus,
  output logic [31:0]           B_bus,
  output logic                  stall,
  output logic                  proto_err,
  mic1_regfile_if.master        bus
);
  typedef enum logic [1:0] {W_IDLE, W_RD, W_WR} w_state_t;
  typedef enum logic {F_IDLE, F_REQ} f_state_t;
  w_state_t    r_ws, w_ws_nxt;
  f_state_t    r_fs, w_fs_nxt;
  logic [31:0] r_c [9];
  logic [31:0] w_c_nxt [9];
  logic [7:0]  r_mbr;
  logic [31:0] r_mem_addr, r_mem_wdata, r_fetch_addr;
  logic        r_proto_err;
  logic        w_go, w_mem_done, w_f_done;
  // r_c index matches C_en bit: 0 MAR, 1 MDR, 2 PC, 3 SP, 4 LV, 5 CPP, 6 TOS, 7 OPC, 8 H
  assign w_mem_done = (r_ws != W_IDLE) & bus.mem_rdy;
  assign w_f_done   = (r_fs == F_REQ) & bus.fetch_rdy;
  assign stall      = ((r_ws != W_IDLE) & ~bus.mem_rdy) | ((r_fs == F_REQ) & ~bus.fetch_rdy);
  assign w_go       = ~stall;
  always_comb begin
    w_ws_nxt = (w_go & rd) ? W_RD : (w_go & wr) ? W_WR : w_mem_done ? W_IDLE : r_ws;
    w_fs_nxt = (w_go & fetch) ? F_REQ : w_f_done ? F_IDLE : r_fs;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ws <= W_IDLE;
      r_fs <= F_IDLE;
    end else begin
      r_ws <= w_ws_nxt;
      r_fs <= w_fs_nxt;
    end
  // Read completion wins over a same-cycle C-bus write to MDR
  always_comb begin
    for (int i = 0; i < 9; i++) w_c_nxt[i] = (w_go & C_en[i]) ? Shift : r_c[i];
    if (w_mem_done & (r_ws == W_RD)) w_c_nxt[1] = bus.mem_rdata;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_c          <= '{default: '0};
      r_mbr        <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_fetch_addr <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_c         <= w_c_nxt;
      r_proto_err <= w_go & rd & wr;
      if (w_f_done) r_mbr <= bus.fetch_rdata;
      if (w_go & (rd | wr)) begin
        r_mem_addr  <= w_c_nxt[0];
        r_mem_wdata <= w_c_nxt[1];
      end
      if (w_go & fetch) r_fetch_addr <= w_c_nxt[2];
    end
  always_comb begin
    B_bus = '0;
    case (B_sel)
      4'd0: B_bus = r_c[1];
      4'd1: B_bus = r_c[2];
      4'd2: B_bus = {{24{r_mbr[7]}}, r_mbr};
      4'd3: B_bus = {24'h0, r_mbr};
      4'd4: B_bus = r_c[3];
      4'd5: B_bus = r_c[4];
      4'd6: B_bus = r_c[5];
      4'd7: B_bus = r_c[6];
      4'd8: B_bus = r_c[7];
      default: B_bus = '0;
    endcase
  end
  assign A_bus          = r_c[8];
  assign proto_err      = r_proto_err;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.mem_rd_req = (r_ws == W_RD);
  assign bus.mem_wr_req = (r_ws == W_WR);
  assign bus.fetch_addr = r_fetch_addr;
  assign bus.fetch_req  = (r_fs == F_REQ);
endmodule

// File: tb/tb_mic1_regfile.sv
// tb_mic1_regfile: directed scenario tests for the MIC-1 register file and memory channels
module tb_mic1_regfile;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Shift;
  logic [8:0]  C_en;
  logic [3:0]  B_sel;
  logic        rd, wr, fetch;
  logic [31:0] A_bus, B_bus;
  logic        stall, proto_err;
  int          pass = 0;
  int          total = 0;
  mic1_regfile_if bus ();
  mic1_regfile dut (
    .clk(clk), .rst_n(rst_n), .Shift(Shift), .C_en(C_en), .B_sel(B_sel),
    .rd(rd), .wr(wr), .fetch(fetch), .A_bus(A_bus), .B_bus(B_bus),
    .stall(stall), .proto_err(proto_err), .bus(bus.master)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; Shift = '0; C_en = '0; B_sel = '0; rd = 0; wr = 0; fetch = 0;
    bus.mem_rdata = '0; bus.mem_rdy = 0; bus.fetch_rdata = '0; bus.fetch_rdy = 0;
    step(); step();
    total++; if (A_bus !== 32'h0) $display("FAIL reset_a got %h exp 0", A_bus); else pass++;
    total++; if (B_bus !== 32'h0) $display("FAIL reset_b got %h exp 0", B_bus); else pass++;
    total++; if ({stall, proto_err, bus.mem_rd_req, bus.mem_wr_req, bus.fetch_req} !== 5'b0)
      $display("FAIL reset_ctl got %b exp 00000", {stall, proto_err, bus.mem_rd_req, bus.mem_wr_req, bus.fetch_req}); else pass++;
    total++; if ({bus.mem_addr, bus.mem_wdata, bus.fetch_addr} !== 96'h0) $display("FAIL reset_addr nonzero"); else pass++;
    #2 rst_n = 1'b1;
  endtask
  task automatic test_cbus();
    logic [3:0] sels [7] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    step();
    Shift = 32'hDEADBEEF; C_en = 9'h1FF;
    step();
    C_en = '0;
    #1;
    total++; if (A_bus !== 32'hDEADBEEF) $display("FAIL cbus_a got %h exp deadbeef", A_bus); else pass++;
    for (int i = 0; i < 7; i++) begin
      B_sel = sels[i]; #1;
      total++; if (B_bus !== 32'hDEADBEEF) $display("FAIL cbus_b sel=%0d got %h exp deadbeef", B_sel, B_bus); else pass++;
    end
    B_sel = 4'd12; #1;
    total++; if (B_bus !== 32'h0) $display("FAIL cbus_b sel=12 got %h exp 0", B_bus); else pass++;
  endtask
  task automatic test_mbr_ext();
    step();
    Shift = 32'd5; C_en = 9'h004; fetch = 1;
    step();
    C_en = '0; fetch = 0; bus.fetch_rdata = 8'h80; bus.fetch_rdy = 1; #1;
    total++; if (bus.fetch_req !== 1'b1) $display("FAIL mbr_req got %b exp 1", bus.fetch_req); else pass++;
    total++; if (bus.fetch_addr !== 32'd5) $display("FAIL mbr_addr got %h exp 5", bus.fetch_addr); else pass++;
    total++; if (stall !== 1'b0) $display("FAIL mbr_stall got %b exp 0", stall); else pass++;
    step();
    bus.fetch_rdy = 0; B_sel = 4'd2; #1;
    total++; if (bus.fetch_req !== 1'b0) $display("FAIL mbr_req_drop got %b exp 0", bus.fetch_req); else pass++;
    total++; if (B_bus !== 32'hFFFFFF80) $display("FAIL mbr_sext got %h exp ffffff80", B_bus); else pass++;
    B_sel = 4'd3; #1;
    total++; if (B_bus !== 32'h00000080) $display("FAIL mbr_zext got %h exp 00000080", B_bus); else pass++;
  endtask
  task automatic test_zero_wait_read();
    step();
    Shift = 32'h10; C_en = 9'h001; rd = 1; B_sel = 4'd0;
    #1;
    total++; if (stall !== 1'b0) $display("FAIL zw_stall_k got %b exp 0", stall); else pass++;
    step();
    rd = 0; bus.mem_rdy = 1; bus.mem_rdata = 32'h1234; C_en = 9'h002; Shift = 32'h9999; #1;
    total++; if (bus.mem_rd_req !== 1'b1) $display("FAIL zw_req got %b exp 1", bus.mem_rd_req); else pass++;
    total++; if (bus.mem_addr !== 32'h10) $display("FAIL zw_addr got %h exp 10", bus.mem_addr); else pass++;
    total++; if (stall !== 1'b0) $display("FAIL zw_stall got %b exp 0", stall); else pass++;
    step();
    C_en = '0; bus.mem_rdy = 0; #1;
    total++; if (B_bus !== 32'h1234) $display("FAIL zw_mdr got %h exp 1234", B_bus); else pass++;
    total++; if (bus.mem_rd_req !== 1'b0) $display("FAIL zw_req_drop got %b exp 0", bus.mem_rd_req); else pass++;
  endtask
  task automatic test_wait_write();
    step();
    Shift = 32'hAA; C_en = 9'h002;
    step();
    Shift = 32'h3; C_en = 9'h001; wr = 1;
    step();
    wr = 0; C_en = 9'h1FF; Shift = 32'h5555;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({stall, bus.mem_wr_req} !== 2'b11) $display("FAIL ww_wait%0d stall/req got %b exp 11", i, {stall, bus.mem_wr_req}); else pass++;
      total++; if (bus.mem_addr !== 32'h3 || bus.mem_wdata !== 32'hAA)
        $display("FAIL ww_hold%0d got %h/%h exp 3/aa", i, bus.mem_addr, bus.mem_wdata); else pass++;
      step();
    end
    bus.mem_rdy = 1; C_en = '0; #1;
    total++; if ({stall, bus.mem_wr_req} !== 2'b01) $display("FAIL ww_done stall/req got %b exp 01", {stall, bus.mem_wr_req}); else pass++;
    step();
    bus.mem_rdy = 0; B_sel = 4'd0; #1;
    total++; if (bus.mem_wr_req !== 1'b0) $display("FAIL ww_req_drop got %b exp 0", bus.mem_wr_req); else pass++;
    total++; if (A_bus !== 32'hDEADBEEF) $display("FAIL ww_h_kept got %h exp deadbeef", A_bus); else pass++;
    total++; if (B_bus !== 32'hAA) $display("FAIL ww_mdr_kept got %h exp aa", B_bus); else pass++;
    B_sel = 4'd4; #1;
    total++; if (B_bus !== 32'hDEADBEEF) $display("FAIL ww_sp_kept got %h exp deadbeef", B_bus); else pass++;
    B_sel = 4'd0;
  endtask
  task automatic test_illegal();
    step();
    rd = 1; wr = 1;
    step();
    rd = 0; wr = 0; bus.mem_rdy = 1; bus.mem_rdata = 32'h77; #1;
    total++; if (proto_err !== 1'b1) $display("FAIL ill_perr got %b exp 1", proto_err); else pass++;
    total++; if ({bus.mem_rd_req, bus.mem_wr_req} !== 2'b10) $display("FAIL ill_req got %b exp 10", {bus.mem_rd_req, bus.mem_wr_req}); else pass++;
    total++; if (bus.mem_addr !== 32'h3) $display("FAIL ill_addr got %h exp 3", bus.mem_addr); else pass++;
    step();
    bus.mem_rdy = 0; #1;
    total++; if (proto_err !== 1'b0) $display("FAIL ill_perr_pulse got %b exp 0", proto_err); else pass++;
    total++; if (B_bus !== 32'h77) $display("FAIL ill_mdr got %h exp 77", B_bus); else pass++;
  endtask
  task automatic test_back_to_back();
    step();
    Shift = 32'h20; C_en = 9'h001; rd = 1;
    step();
    bus.mem_rdy = 1; bus.mem_rdata = 32'h11; Shift = 32'h24;
    step();
    rd = 0; C_en = '0; bus.mem_rdata = 32'h22; #1;
    total++; if (bus.mem_rd_req !== 1'b1) $display("FAIL b2b_req got %b exp 1", bus.mem_rd_req); else pass++;
    total++; if (bus.mem_addr !== 32'h24) $display("FAIL b2b_addr got %h exp 24", bus.mem_addr); else pass++;
    total++; if (B_bus !== 32'h11) $display("FAIL b2b_mdr1 got %h exp 11", B_bus); else pass++;
    step();
    bus.mem_rdy = 0; #1;
    total++; if (bus.mem_rd_req !== 1'b0) $display("FAIL b2b_req_drop got %b exp 0", bus.mem_rd_req); else pass++;
    total++; if (B_bus !== 32'h22) $display("FAIL b2b_mdr2 got %h exp 22", B_bus); else pass++;
  endtask
  task automatic test_reset_mid();
    step();
    rd = 1;
    step();
    rd = 0; bus.mem_rdy = 0; #1;
    total++; if ({stall, bus.mem_rd_req} !== 2'b11) $display("FAIL rm_pending got %b exp 11", {stall, bus.mem_rd_req}); else pass++;
    #1 rst_n = 1'b0;
    #1;
    total++; if ({stall, bus.mem_rd_req} !== 2'b00) $display("FAIL rm_async got %b exp 00", {stall, bus.mem_rd_req}); else pass++;
    total++; if (B_bus !== 32'h0 || A_bus !== 32'h0) $display("FAIL rm_regs got %h/%h exp 0/0", B_bus, A_bus); else pass++;
    #1 rst_n = 1'b1;
  endtask
  initial begin
    test_reset();
    test_cbus();
    test_mbr_ext();
    test_zero_wait_read();
    test_wait_write();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    step();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
